// File: rtl/lsb_arb_pkg.sv
// Shared definitions for the LSB-test arbiter.
//   - Default parameter values for the arbiter top.
//   - id_w(): width of a requester index (at least 1 bit).
//   - slot_state_e: encoding of the one-entry response slot.
package lsb_arb_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 16;

    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/lsb_test_unit.sv
// Shared combinational LSB-test datapath.
// Ports:
//   a  in   DATA_W  word under test
//   y  out  1       1 when a[0] is 0, 0 when a[0] is 1
// DATA_W must be at least 2.
module lsb_test_unit #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    output logic              y
);

    // Only bit 0 matters; the upper bits are deliberately ignored.
    logic unused_upper;
    assign unused_upper = ^a[DATA_W-1:1];

    assign y = a[0] ? 1'b0 : 1'b1;

endmodule

// File: rtl/lsb_test_arbiter.sv
// Round-robin arbiter sharing one LSB-test unit between NUM_REQ requesters, with a
// one-entry registered response slot under valid/ready backpressure.
// Ports:
//   clk         in   1               rising-edge clock
//   rst         in   1               synchronous active-high reset
//   req_valid   in   NUM_REQ         per-requester request valid
//   req_data    in   NUM_REQ*DATA_W  packed words, requester i at [i*DATA_W +: DATA_W]
//   req_ready   out  NUM_REQ         one-hot (or zero) accept
//   rsp_valid   out  1               response slot is full
//   rsp_ready   in   1               downstream accepts the response
//   rsp_y       out  1               inverse of granted word bit 0
//   rsp_id      out  ID_W            index of the granted requester
//   rsp_data    out  DATA_W          echo of the granted word
//   done_count  out  CNT_W           saturating count of response handshakes
module lsb_test_arbiter
    import lsb_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned  DATA_W  = DATA_W_DEF,
    parameter int unsigned  CNT_W   = CNT_W_DEF,
    localparam int unsigned ID_W    = id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_y,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [CNT_W-1:0]          done_count
);

    slot_state_e       state;
    logic [ID_W-1:0]   rr_ptr;

    logic              can_accept;
    logic              rsp_fire;
    logic              hi_found;
    logic              lo_found;
    logic [ID_W-1:0]   hi_idx;
    logic [ID_W-1:0]   lo_idx;
    logic              grant_valid;
    logic [ID_W-1:0]   grant;
    logic [DATA_W-1:0] grant_word;
    logic              test_y;

    assign rsp_valid  = (state == StFull);
    assign can_accept = (state == StEmpty) || rsp_ready;
    assign rsp_fire   = rsp_valid && rsp_ready;

    // Rotating priority: the lowest valid index at or above rr_ptr wins; if there is
    // none, the lowest valid index overall wins (the scan has wrapped past the top).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
    end

    assign grant_valid = !rst && can_accept && lo_found;
    assign grant       = hi_found ? hi_idx : lo_idx;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready[i] = grant_valid && (grant == ID_W'(i));
        end
    end

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant == ID_W'(i)) begin
                grant_word = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    lsb_test_unit #(
        .DATA_W(DATA_W)
    ) u_test_unit (
        .a(grant_word),
        .y(test_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StEmpty;
            rr_ptr     <= '0;
            rsp_y      <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            done_count <= '0;
        end else begin
            // A grant refills the slot even when the current result is being drained.
            if (grant_valid) begin
                state    <= StFull;
                rsp_y    <= test_y;
                rsp_id   <= grant;
                rsp_data <= grant_word;
                rr_ptr   <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
            end else if (rsp_fire) begin
                state <= StEmpty;
            end
            if (rsp_fire && (done_count != '1)) begin
                done_count <= done_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lsb_test_arbiter.sv
module tb_lsb_test_arbiter;

    localparam int NR   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_y;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic [3:0]  done_count;

    logic        b_rst;
    logic [2:0]  b_req_valid;
    logic [23:0] b_req_data;
    logic [2:0]  b_req_ready;
    logic        b_rsp_valid;
    logic        b_rsp_ready;
    logic        b_rsp_y;
    logic [1:0]  b_rsp_id;
    logic [7:0]  b_rsp_data;
    logic [15:0] b_done_count;

    int n_chk  = 0;
    int n_fail = 0;

    lsb_test_arbiter #(.NUM_REQ(4), .DATA_W(8), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_id(rsp_id), .rsp_data(rsp_data), .done_count(done_count)
    );

    lsb_test_arbiter #(.NUM_REQ(3), .DATA_W(8), .CNT_W(16)) dut_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_y(b_rsp_y), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
        .done_count(b_done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for dut_a: slot contents, pointer and counter as plain integers.
    int m_full = 0, m_y = 0, m_id = 0, m_data = 0, m_ptr = 0, m_cnt = 0;

    always @(negedge clk) begin
        logic [3:0] exp_ready;
        int g, idx;
        bit gv;
        exp_ready = 4'b0;
        gv = 1'b0;
        g = 0;
        if (!rst && (m_full == 0 || rsp_ready)) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (!gv && req_valid[idx[1:0]]) begin
                    gv = 1'b1;
                    g  = idx;
                end
            end
        end
        if (gv) exp_ready[g[1:0]] = 1'b1;
        chk("m_req_ready", 32'(req_ready), 32'(exp_ready));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(m_full));
        chk("m_done_count", 32'(done_count), 32'(m_cnt));
        if (m_full != 0) begin
            chk("m_rsp_y", 32'(rsp_y), 32'(m_y));
            chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
            chk("m_rsp_data", 32'(rsp_data), 32'(m_data));
        end
        if (rst) begin
            m_full = 0; m_y = 0; m_id = 0; m_data = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_full != 0 && rsp_ready && m_cnt < CMAX) m_cnt++;
            if (gv) begin
                m_full = 1;
                m_data = int'(req_data[g*8 +: 8]);
                m_y    = (m_data % 2 == 0) ? 1 : 0;
                m_id   = g;
                m_ptr  = (g + 1) % NR;
            end else if (m_full != 0 && rsp_ready) begin
                m_full = 0;
            end
        end
    end

    int exp_ids[5] = '{0, 1, 2, 3, 0};
    int exp_ys[5]  = '{0, 1, 0, 1, 0};

    initial begin
        rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b0;
        req_data = {8'h04, 8'h03, 8'h02, 8'h01};
        b_rst = 1'b1; b_req_valid = 3'b0; b_rsp_ready = 1'b0;
        b_req_data = {8'h12, 8'h11, 8'h10};

        // Reset held two cycles with every requester valid.
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_done", 32'(done_count), 32'h0);
            chk("rst_rsp_fields", {rsp_y, rsp_id, rsp_data}, 32'h0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ptr0", 32'(req_ready), 32'h1);
        req_valid = 4'b0;

        // Rotation with all four valid.
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("rot_id", 32'(rsp_id), 32'(exp_ids[c]));
            chk("rot_y", 32'(rsp_y), 32'(exp_ys[c]));
        end
        chk("rot_done", 32'(done_count), 32'd4);
        req_valid = 4'b0;
        step();
        chk("rot_drain", 32'(rsp_valid), 32'h0);

        // Single request from requester 2.
        req_data[23:16] = 8'hA6;
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0;
        chk("single_resp", {rsp_valid, rsp_y, rsp_id, rsp_data}, {1'b1, 1'b1, 2'd2, 8'hA6});
        step();
        chk("single_done", 32'(done_count), 32'd6);
        chk("single_empty", 32'(rsp_valid), 32'h0);

        // Backpressure: pointer is 3, so scan 3,0 picks 0.
        rsp_ready = 1'b0; req_valid = 4'b0011;
        #1;
        chk("bp_first_ready", 32'(req_ready), 32'h1);
        step();
        for (int c = 0; c < 4; c++) begin
            chk("bp_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd0, 8'h01});
            chk("bp_no_grant", 32'(req_ready), 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h2);
        step();
        chk("bp_next", {rsp_valid, rsp_id, rsp_data, done_count}, {1'b1, 2'd1, 8'h02, 4'd7});
        req_valid = 4'b0;
        step();
        chk("bp_done", 32'(done_count), 32'd8);

        // Counter saturation with a 4-bit counter.
        req_valid = 4'b1111;
        repeat (20) step();
        req_valid = 4'b0;
        step();
        chk("sat_done", 32'(done_count), 32'hF);
        step();
        chk("sat_hold", 32'(done_count), 32'hF);

        // Three requesters: reset with the slot full, then pointer wrap 2 -> 0.
        b_rst = 1'b0; b_req_valid = 3'b001;
        step();
        b_req_valid = 3'b0;
        chk("b_full", {b_rsp_valid, b_rsp_id}, {1'b1, 2'd0});
        b_rst = 1'b1; b_req_valid = 3'b111;
        #1;
        chk("b_rst_ready", 32'(b_req_ready), 32'h0);
        step();
        chk("b_rst_state", {b_rsp_valid, b_done_count}, 32'h0);
        b_rst = 1'b0; b_rsp_ready = 1'b1; b_req_valid = 3'b100;
        #1;
        chk("b_grant2", 32'(b_req_ready), 32'h4);
        step();
        chk("b_resp2", {b_rsp_valid, b_rsp_y, b_rsp_id, b_rsp_data}, {1'b1, 1'b1, 2'd2, 8'h12});
        b_req_valid = 3'b111;
        #1;
        chk("b_wrap_ready", 32'(b_req_ready), 32'h1);
        step();
        chk("b_resp0", {b_rsp_id, b_rsp_data, b_rsp_y}, {2'd0, 8'h10, 1'b1});
        chk("b_done1", 32'(b_done_count), 32'd1);
        b_req_valid = 3'b0;
        step();
        chk("b_done2", {b_rsp_valid, b_done_count}, {1'b0, 16'd2});

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
